// File: rtl/hnmpp.sv
// Hit-Nodule-Map: one hit flag per SSID, filled in WRITE, queried in READ, wiped by a word-per-cycle CLEAR sweep.
// Optional HNMPP_HITCOUNT_EN adds HNM_hitCount, the number of distinct flags set in the current event.
module hnmpp #(
  parameter int SSID_WIDTH = 8,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SSID_WIDTH-1:0] SSID,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clear,
  output logic                  HNM_writeReady,
  output logic                  HNM_readReady,
  output logic                  HNM_SSIDHit,
`ifdef HNMPP_HITCOUNT_EN
  output logic [SSID_WIDTH:0]   HNM_hitCount,
`endif
  output logic                  HNM_hitValid
);

  localparam int BW = $clog2(WORD_WIDTH);
  localparam int PW = SSID_WIDTH - BW;
  localparam int NW = (2**SSID_WIDTH) / WORD_WIDTH;

  typedef enum logic [1:0] {S_CLEAR, S_WRITE, S_READ} state_e;

  state_e                          state_q, state_d;
  logic [PW-1:0]                   ptr_q, ptr_d;
  logic                            hit_q, hit_d;
  logic                            vld_q, vld_d;
  logic [NW-1:0][WORD_WIDTH-1:0]   map_q, map_d;

  logic [PW-1:0] word_idx;
  logic [BW-1:0] bit_idx;
  logic          flag, wr_acc, rd_acc;

  assign word_idx = SSID[SSID_WIDTH-1:BW];
  assign bit_idx  = SSID[BW-1:0];
  assign flag     = map_q[word_idx][bit_idx];
  // clear wins over any read/write presented in the same cycle
  assign wr_acc   = write && (state_q == S_WRITE) && !clear;
  assign rd_acc   = read && (state_q != S_CLEAR) && !clear;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    map_d   = map_q;
    hit_d   = hit_q;
    vld_d   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        map_d[ptr_q] = '0;
        if (ptr_q == PW'(NW-1)) begin
          state_d = S_WRITE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_acc) map_d[word_idx][bit_idx] = 1'b1;
        if (rd_acc) state_d = S_READ;
      end
      default: ;
    endcase
    if (rd_acc) begin
      // same-cycle write to the shared SSID bus is forwarded into the answer
      hit_d = flag | wr_acc;
      vld_d = 1'b1;
    end
    if (clear) begin
      state_d = S_CLEAR;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      hit_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hit_q   <= hit_d;
      vld_q   <= vld_d;
    end
  end

  // storage needs no reset: the sweep that follows reset zeroes it before any read is accepted
  always_ff @(posedge clk) begin
    map_q <= map_d;
  end

  assign HNM_writeReady = (state_q == S_WRITE);
  assign HNM_readReady  = (state_q == S_WRITE) || (state_q == S_READ);
  assign HNM_SSIDHit    = hit_q;
  assign HNM_hitValid   = vld_q;

`ifdef HNMPP_HITCOUNT_EN
  localparam logic [SSID_WIDTH:0] CNT_MAX = (SSID_WIDTH+1)'(2**SSID_WIDTH);
  logic [SSID_WIDTH:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !flag && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    if (clear || (state_q == S_CLEAR)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign HNM_hitCount = cnt_q;
`endif

endmodule

// File: tb/tb_hnmpp.sv
// Directed bench for hnmpp: reset sweep, write/read, read-phase freeze, clear, forwarding, reset mid-phase.
module tb_hnmpp;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] SSID;
  logic       write, read, clear;
  logic       HNM_writeReady, HNM_readReady, HNM_SSIDHit, HNM_hitValid;
`ifdef HNMPP_HITCOUNT_EN
  logic [8:0] hit_count;
`endif

  int tests = 0;
  int fails = 0;

  hnmpp #(.SSID_WIDTH(8), .WORD_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .SSID           (SSID),
    .write          (write),
    .read           (read),
    .clear          (clear),
    .HNM_writeReady (HNM_writeReady),
    .HNM_readReady  (HNM_readReady),
    .HNM_SSIDHit    (HNM_SSIDHit),
`ifdef HNMPP_HITCOUNT_EN
    .HNM_hitCount   (hit_count),
`endif
    .HNM_hitValid   (HNM_hitValid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; SSID = '0; write = 0; read = 0; clear = 0;
    #2;
    tests++;
    if ({HNM_writeReady, HNM_readReady, HNM_SSIDHit, HNM_hitValid} !== 4'b0000) begin
      fails++; $display("FAIL reset_outputs got=%b exp=0000",
        {HNM_writeReady, HNM_readReady, HNM_SSIDHit, HNM_hitValid});
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if ({HNM_writeReady, HNM_readReady} !== 2'b00) begin
        fails++; $display("FAIL sweep_ready cyc=%0d got=%b exp=00", i, {HNM_writeReady, HNM_readReady});
      end
      tick();
    end
    tests++;
    if ({HNM_writeReady, HNM_readReady} !== 2'b11) begin
      fails++; $display("FAIL ready_after_sweep got=%b exp=11", {HNM_writeReady, HNM_readReady});
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd_ssid [3] = '{8'h03, 8'h04, 8'hFF};
    logic       rd_exp  [3] = '{1'b1, 1'b0, 1'b1};
    write = 1; SSID = 8'h03; tick();
    SSID = 8'hFF; tick();
    write = 0; read = 1;
    for (int i = 0; i < 3; i++) begin
      SSID = rd_ssid[i];
      tick();
      tests++;
      if ({HNM_hitValid, HNM_SSIDHit} !== {1'b1, rd_exp[i]}) begin
        fails++; $display("FAIL b2b_read%0d valid,hit got=%b%b exp=1%b", i, HNM_hitValid, HNM_SSIDHit, rd_exp[i]);
      end
      tests++;
      if (HNM_writeReady !== 1'b0 || HNM_readReady !== 1'b1) begin
        fails++; $display("FAIL read_state_ready%0d got=%b%b exp=01", i, HNM_writeReady, HNM_readReady);
      end
    end
    read = 0; tick();
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit} !== 2'b01) begin
      fails++; $display("FAIL idle_hold valid,hit got=%b%b exp=01", HNM_hitValid, HNM_SSIDHit);
    end
  endtask

  task automatic test_read_freeze();
    write = 1; SSID = 8'h10; tick();
    write = 0;
    tests++;
    if (HNM_hitValid !== 1'b0) begin
      fails++; $display("FAIL write_in_read valid got=%b exp=0", HNM_hitValid);
    end
    read = 1; tick();
    read = 0;
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit} !== 2'b10) begin
      fails++; $display("FAIL frozen_map valid,hit got=%b%b exp=10", HNM_hitValid, HNM_SSIDHit);
    end
    // restore hit=1 so later zero answers are meaningful
    SSID = 8'hFF; read = 1; tick(); read = 0;
  endtask

  task automatic test_clear_and_forward();
    clear = 1; read = 1; SSID = 8'h03; tick();
    clear = 0;
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit, HNM_writeReady, HNM_readReady} !== 4'b0100) begin
      fails++; $display("FAIL clear_override v,h,wr,rr got=%b exp=0100",
        {HNM_hitValid, HNM_SSIDHit, HNM_writeReady, HNM_readReady});
    end
    tick();
    read = 0;
    tests++;
    if (HNM_hitValid !== 1'b0) begin
      fails++; $display("FAIL read_in_sweep valid got=%b exp=0", HNM_hitValid);
    end
    // restart the sweep part-way: 16 fresh cycles are needed after it
    for (int i = 0; i < 6; i++) tick();
    clear = 1; tick(); clear = 0;
    for (int i = 0; i < 15; i++) tick();
    tests++;
    if (HNM_readReady !== 1'b0) begin
      fails++; $display("FAIL restart_sweep ready got=%b exp=0", HNM_readReady);
    end
    tick();
    tests++;
    if ({HNM_writeReady, HNM_readReady} !== 2'b11) begin
      fails++; $display("FAIL ready_after_clear got=%b exp=11", {HNM_writeReady, HNM_readReady});
    end
    write = 1; read = 1; SSID = 8'h55; tick();
    write = 0;
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit, HNM_writeReady} !== 3'b110) begin
      fails++; $display("FAIL fwd_write_read v,h,wr got=%b exp=110", {HNM_hitValid, HNM_SSIDHit, HNM_writeReady});
    end
    SSID = 8'h03; tick();
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit} !== 2'b10) begin
      fails++; $display("FAIL cleared_flag valid,hit got=%b%b exp=10", HNM_hitValid, HNM_SSIDHit);
    end
    SSID = 8'h55; tick();
    read = 0;
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit} !== 2'b11) begin
      fails++; $display("FAIL fwd_committed valid,hit got=%b%b exp=11", HNM_hitValid, HNM_SSIDHit);
    end
  endtask

  task automatic test_reset_mid_phase();
    tick();
    reset = 1'b0; #1;
    tests++;
    if ({HNM_writeReady, HNM_readReady, HNM_SSIDHit, HNM_hitValid} !== 4'b0000) begin
      fails++; $display("FAIL async_reset got=%b exp=0000",
        {HNM_writeReady, HNM_readReady, HNM_SSIDHit, HNM_hitValid});
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    read = 1; SSID = 8'h55; tick(); read = 0;
    tests++;
    if ({HNM_hitValid, HNM_SSIDHit} !== 2'b10) begin
      fails++; $display("FAIL after_reset_sweep valid,hit got=%b%b exp=10", HNM_hitValid, HNM_SSIDHit);
    end
  endtask

`ifdef HNMPP_HITCOUNT_EN
  task automatic test_hitcount();
    logic [7:0] wr_ssid [3] = '{8'h01, 8'h01, 8'h02};
    clear = 1; tick(); clear = 0;
    for (int i = 0; i < 16; i++) tick();
    write = 1;
    for (int i = 0; i < 3; i++) begin
      SSID = wr_ssid[i]; tick();
    end
    write = 0;
    tests++;
    if (hit_count !== 9'd2) begin
      fails++; $display("FAIL hitcount got=%0d exp=2", hit_count);
    end
    clear = 1; tick(); clear = 0;
    tick(); tick();
    reset = 1'b0; #1;
    tests++;
    if ({hit_count, HNM_writeReady, HNM_readReady, HNM_hitValid} !== 12'd0) begin
      fails++; $display("FAIL reset_mid_sweep cnt=%0d wr=%b rr=%b v=%b exp all 0",
        hit_count, HNM_writeReady, HNM_readReady, HNM_hitValid);
    end
    #1 reset = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_read_freeze();
    test_clear_and_forward();
    test_reset_mid_phase();
`ifdef HNMPP_HITCOUNT_EN
    test_hitcount();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
